// File: rtl/spi_slave8.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave8
// Brief    : 8-bit SPI slave for all CPOL/CPHA modes, oversampled on sys_clk,
//            with a one-deep reply holding register. Define
//            SPI_SLAVE_MISO_OE_EN to add miso_oe for a shared MISO line.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave8 #(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       nCS,
  input  logic       DCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_empty,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic       miso_oe
`endif
);

  localparam logic [2:0] c_LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_ncs_sync, r_dclk_sync, r_mosi_sync;
  logic                   r_ncs_hist, r_dclk_hist;
  logic [SYNC_STAGES:0]   r_settle;

  logic [7:0] r_tx_shift, r_hold, r_rx_data;
  logic [6:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic       r_tx_empty, r_tx_underrun, r_rx_valid, r_miso;

  logic w_ncs_s, w_dclk_s, w_mosi_s, w_ncs_fall;
  logic w_lead, w_trail, w_active, w_sample, w_shift, w_reload;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ncs_sync  <= '1;
      r_dclk_sync <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_ncs_hist  <= 1'b1;
      r_dclk_hist <= CPOL;
      r_settle    <= '0;
    end else begin
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
      r_dclk_sync <= {r_dclk_sync[SYNC_STAGES-2:0], DCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
      r_dclk_hist <= r_dclk_sync[SYNC_STAGES-1];
      r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];
  assign w_dclk_s = r_dclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // Falling edges are only trusted once real pin samples have flushed the
  // reset values out of the chain, so a reset with nCS held low cannot
  // restart a transfer mid-byte.
  assign w_ncs_fall = r_settle[SYNC_STAGES] & r_ncs_hist & ~w_ncs_s;

  assign w_lead   = (r_dclk_hist == CPOL) && (w_dclk_s != CPOL);
  assign w_trail  = (r_dclk_hist != CPOL) && (w_dclk_s == CPOL);
  assign w_active = (r_state == S_ACTIVE) && !w_ncs_s;
  assign w_sample = w_active && (CPHA ? w_trail : w_lead);
  assign w_shift  = w_active && (CPHA ? w_lead : w_trail);
  assign w_reload = ((r_state == S_LOAD) && !w_ncs_s) ||
                    (w_active && w_trail &&
                     (CPHA ? (r_bit_cnt == c_LAST_BIT) : (r_bit_cnt == 3'd0)));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ncs_fall) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_ACTIVE;
      S_ACTIVE: w_state_nxt = S_ACTIVE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_ncs_s) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_tx_empty    <= 1'b1;
      r_tx_underrun <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_bit_cnt     <= '0;
      r_miso        <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      r_rx_valid    <= 1'b0;

      // A write in the reload cycle lands in holding after the old state
      // has been handed to the shifter.
      if (tx_wr) begin
        r_hold     <= tx_data;
        r_tx_empty <= 1'b0;
      end else if (w_reload) begin
        r_tx_empty <= 1'b1;
      end

      if (w_reload) begin
        r_tx_shift    <= r_tx_empty ? UNDERRUN_BYTE : r_hold;
        r_tx_underrun <= r_tx_empty;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      if (r_state != S_ACTIVE) begin
        r_miso <= 1'b0;
      end else if (w_shift && CPHA) begin
        r_miso <= r_tx_shift[7];
      end

      if (r_state != S_ACTIVE) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
        if (r_bit_cnt == c_LAST_BIT) begin
          r_rx_data  <= {r_rx_shift, w_mosi_s};
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign MISO        = (r_state == S_IDLE) ? 1'b0 : (CPHA ? r_miso : r_tx_shift[7]);
  assign tx_empty    = r_tx_empty;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = ~w_ncs_s;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign miso_oe = (r_state == S_LOAD) || (r_state == S_ACTIVE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave8.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave8
// Brief    : Bench for spi_slave8: bit-banged SPI master plus a byte-level
//            model of the reply holding register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave8;

  localparam int SYNC = 2;
  localparam int H    = 4;   // sys_clk cycles per DCLK half period

  logic       sys_clk = 1'b0;
  logic       rst, nCS, DCLK, MOSI, MISO, CPOL, CPHA, tx_wr;
  logic       tx_empty, tx_underrun, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       miso_oe;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q [$];
  int         und_cnt  = 0;
  int         und_snap = 0;

  // reference model of the holding register
  bit         m_hold_v;
  logic [7:0] m_hold_d;
  int         m_und;

  logic [7:0] mosi_b [3];
  bit         wr_en  [3];
  logic [7:0] wr_val [3];

  always #5 sys_clk = ~sys_clk;

  spi_slave8 #(.SYNC_STAGES(SYNC), .UNDERRUN_BYTE(8'h00)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .nCS         (nCS),
    .DCLK        (DCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_empty    (tx_empty),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy)
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    .miso_oe     (miso_oe)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        und_snap = und_cnt;
      end
      if (tx_underrun) und_cnt++;
    end
  end

  // Every byte start hands the holding content (or the underrun byte) out.
  function automatic logic [7:0] model_start();
    logic [7:0] v;
    v = m_hold_v ? m_hold_d : 8'h00;
    if (!m_hold_v) m_und++;
    m_hold_v = 1'b0;
    return v;
  endfunction

  task automatic wr(input logic [7:0] v);
    tx_data = v;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr    = 1'b0;
    m_hold_v = 1'b1;
    m_hold_d = v;
  endtask

  task automatic check_reset_vals(input string nm);
    check($sformatf("%s_miso", nm), MISO, 0);
    check($sformatf("%s_empty", nm), tx_empty, 1);
    check($sformatf("%s_und", nm), tx_underrun, 0);
    check($sformatf("%s_rxd", nm), rx_data, 0);
    check($sformatf("%s_rxv", nm), rx_valid, 0);
    check($sformatf("%s_busy", nm), busy, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check($sformatf("%s_oe", nm), miso_oe, 0);
`endif
  endtask

  // nb bytes under one nCS; cut>0 truncates the last byte to cut bits;
  // do_rst pulses rst right after the truncated byte; swr writes swr_val
  // coincident with the LOAD reload.
  task automatic xfer(input logic pol, input logic pha, input int nb, input int cut,
                      input bit do_rst, input bit swr, input logic [7:0] swr_val,
                      input string nm);
    logic [7:0] exp_tx [$];
    logic [7:0] mg [3];
    logic [7:0] mo;
    int rx0, und0, mu0, ub, nfull, nbits;
    bit und_first;
    rx0   = rx_q.size();
    und0  = und_cnt;
    mu0   = m_und;
    ub    = 0;
    nfull = (cut > 0) ? nb - 1 : nb;
    CPOL = pol; CPHA = pha; DCLK = pol; MOSI = 1'b0;
    repeat (4) @(negedge sys_clk);
    nCS = 1'b0;
    und_first = !m_hold_v;
    exp_tx.push_back(model_start());
    if (nfull == 1) ub = m_und - mu0;
    for (int s = 1; s <= SYNC + 2; s++) begin
      @(negedge sys_clk);
      if (s == SYNC + 1 && swr) begin
        tx_data = swr_val; tx_wr = 1'b1;
        m_hold_v = 1'b1; m_hold_d = swr_val;
      end else begin
        tx_wr = 1'b0;
      end
      if (s == SYNC + 2 && swr) begin
        check($sformatf("%s_ld_und", nm), tx_underrun, und_first);
        check($sformatf("%s_ld_empty", nm), tx_empty, 0);
      end
    end
    repeat (4) @(negedge sys_clk);
    check($sformatf("%s_busy1", nm), busy, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
    check($sformatf("%s_oe1", nm), miso_oe, 1);
`endif
    for (int b = 0; b < nb; b++) begin
      if (b > 0) exp_tx.push_back(model_start());
      if (b > 0 && b == nfull - 1) ub = m_und - mu0;
      nbits = (b == nb - 1 && cut > 0) ? cut : 8;
      mo    = mosi_b[b];
      mg[b] = 8'h00;
      for (int i = 0; i < nbits; i++) begin
        if (!pha) begin
          mg[b][7-i] = MISO;
          MOSI = mo[7-i];
        end
        DCLK = ~pol;
        if (pha) MOSI = mo[7-i];
        repeat (H) @(negedge sys_clk);
        if (pha) mg[b][7-i] = MISO;
        DCLK = pol;
        if (i == 3 && wr_en[b]) begin
          tx_data = wr_val[b]; tx_wr = 1'b1;
          m_hold_v = 1'b1; m_hold_d = wr_val[b];
        end
        @(negedge sys_clk);
        tx_wr = 1'b0;
        repeat (H - 1) @(negedge sys_clk);
      end
    end
    if (do_rst) begin
      rst = 1'b1;
      @(negedge sys_clk);
      check_reset_vals($sformatf("%s_mid", nm));
      rst = 1'b0;
      m_hold_v = 1'b0;
    end else if (cut == 0) begin
      void'(model_start());
    end
    repeat (8) @(negedge sys_clk);
    nCS = 1'b1;
    repeat (8) @(negedge sys_clk);
    check($sformatf("%s_busy0", nm), busy, 0);
    check($sformatf("%s_miso_idle", nm), MISO, 0);
    check($sformatf("%s_nrx", nm), rx_q.size() - rx0, nfull);
    for (int b = 0; b < nfull; b++) begin
      check($sformatf("%s_rx%0d", nm, b),
            (rx0 + b < rx_q.size()) ? {24'h0, rx_q[rx0 + b]} : 32'hFFFF_FFFF, mosi_b[b]);
      check($sformatf("%s_tx%0d", nm, b), mg[b], exp_tx[b]);
    end
    check($sformatf("%s_und_all", nm), und_cnt - und0, m_und - mu0);
    if (nfull > 0) begin
      check($sformatf("%s_und_bytes", nm), und_snap - und0, ub);
      check($sformatf("%s_rxd_last", nm), rx_data, mosi_b[nfull - 1]);
    end
    check($sformatf("%s_empty", nm), tx_empty, !m_hold_v);
  endtask

  initial begin
    logic rp, rh;
    int   rn;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rp, rh;
    int   rn;
    rst = 1'b1; nCS = 1'b1; DCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; tx_data = 8'h00; tx_wr = 1'b0;
    m_hold_v = 1'b0; m_hold_d = 8'h00; m_und = 0;
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 1'b0; wr_val[i] = 8'h00; mosi_b[i] = 8'h00;
    end
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // mode 0 single byte
    wr(8'h3C); mosi_b[0] = 8'hA5;
    xfer(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'h00, "m0");

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      wr(8'h7E); mosi_b[0] = 8'h81;
      xfer(m[1], m[0], 1, 0, 1'b0, 1'b0, 8'h00, $sformatf("mode%0d", m));
    end

    // three-byte burst with a refill during the first byte only
    wr(8'hB1);
    mosi_b[0] = 8'h01; mosi_b[1] = 8'h02; mosi_b[2] = 8'h03;
    wr_en[0] = 1'b1; wr_val[0] = 8'hB2;
    xfer(1'b0, 1'b0, 3, 0, 1'b0, 1'b0, 8'h00, "burst");
    wr_en[0] = 1'b0;

    // aborted byte after 5 clocks, then a clean byte
    wr(8'h11); mosi_b[0] = 8'hFF;
    xfer(1'b0, 1'b0, 1, 5, 1'b0, 1'b0, 8'h00, "part");
    mosi_b[0] = 8'h5A;
    xfer(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'h00, "after_part");

    // write coincident with the LOAD reload while holding is empty
    mosi_b[0] = 8'h12; mosi_b[1] = 8'h34;
    xfer(1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 8'hD7, "coinc");

    // reset after bit 3, then a full byte
    wr(8'h44); mosi_b[0] = 8'h99;
    xfer(1'b0, 1'b0, 1, 3, 1'b1, 1'b0, 8'h00, "rst");
    wr(8'h66); mosi_b[0] = 8'hC3;
    xfer(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'h00, "after_rst");

    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rn = int'($urandom_range(1, 3));
      for (int b = 0; b < 3; b++) begin
        mosi_b[b] = 8'($urandom_range(0, 255));
        wr_en[b]  = 1'($urandom_range(0, 1));
        wr_val[b] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 1) == 1) wr(8'($urandom_range(0, 255)));
      xfer(rp, rh, rn, 0, 1'b0, 1'b0, 8'h00, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
